// File: rtl/mips_mc_controller.sv
// Multicycle control unit for the TinyMIPS core with a parametrised memory bus width.
// A 32-bit instruction is fetched in BEATS = 32/WIDTH beats, one IR slot per beat.
// Memory states wait on memready. The unit also decodes bne and flags illegal opcodes.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   op                   instr[31:26]
//   zero                 ALU zero flag, used by beq/bne
//   memready             memory access completes this cycle
//   memread, memwrite    memory strobes
//   alusrca, memtoreg,   datapath selects and enables
//   iord, regwrite,
//   regdst
//   pcen                 PC register enable
//   pcsource, alusrcb,   datapath mux and ALU selects
//   aluop
//   irwrite              one-hot IR slot write enable, one bit per fetch beat
//   illegal              one-cycle pulse in DECODE for an unrecognised opcode
module mips_mc_controller #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BEATS = 32 / WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             memready,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrca,
  output logic             memtoreg,
  output logic             iord,
  output logic             regwrite,
  output logic             regdst,
  output logic             pcen,
  output logic [1:0]       pcsource,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [BEATS-1:0] irwrite,
  output logic             illegal
);

  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [5:0] OpLb   = 6'b100000;
  localparam logic [5:0] OpSb   = 6'b101000;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  // All fetch beats share one state; beat_q selects the IR slot.
  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StLbRd,
    StLbWr,
    StSbWr,
    StRtEx,
    StRtWr,
    StBeqEx,
    StBneEx,
    StJEx,
    StAddiEx,
    StAddiWr
  } state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcen     = 1'b0;
    pcsource = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    irwrite  = '0;
    illegal  = 1'b0;

    unique case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;  // PC + WIDTH/8
        if (memready) begin
          irwrite = BEATS'(1) << beat_q;
          pcen    = 1'b1;
          if (beat_q == BeatW'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = StDecode;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDecode: begin
        alusrcb = 2'b11;  // branch target precompute
        case (op)
          OpLb, OpSb: state_d = StMemAdr;
          OpRtype:    state_d = StRtEx;
          OpBeq:      state_d = StBeqEx;
          OpBne:      state_d = StBneEx;
          OpJ:        state_d = StJEx;
          OpAddi:     state_d = StAddiEx;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OpSb) ? StSbWr : StLbRd;
      end
      StLbRd: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (memready) state_d = StLbWr;
      end
      StLbWr: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = StFetch;
      end
      StSbWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (memready) state_d = StFetch;
      end
      StRtEx: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = StRtWr;
      end
      StRtWr: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = StFetch;
      end
      StBeqEx, StBneEx: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pcen     = (state_q == StBeqEx) ? zero : ~zero;
        state_d  = StFetch;
      end
      StJEx: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
        state_d  = StFetch;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWr;
      end
      StAddiWr: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      default: begin
        state_d = StFetch;
        beat_d  = '0;
      end
    endcase

    // Outputs are held quiet for the whole reset period, including mid-instruction aborts.
    if (rst) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrca  = 1'b0;
      memtoreg = 1'b0;
      iord     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      pcen     = 1'b0;
      pcsource = 2'b00;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      irwrite  = '0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller at WIDTH 8, 16 and 32, run side by side.
// Each lane has a reference model that expands an opcode into the list of steps the
// instruction goes through. Memory steps are repeated while memready is low.
module tb_mips_mc_controller;

  localparam int NCycles = 3000;

  localparam int KFetch   = 0;
  localparam int KDecode  = 1;
  localparam int KMemAdr  = 2;
  localparam int KLbRd    = 3;
  localparam int KLbWr    = 4;
  localparam int KSbWr    = 5;
  localparam int KRtEx    = 6;
  localparam int KRtWr    = 7;
  localparam int KBeqEx   = 8;
  localparam int KBneEx   = 9;
  localparam int KJEx     = 10;
  localparam int KAddiEx  = 11;
  localparam int KAddiWr  = 12;

  logic       clk = 1'b0;
  logic       rst [3];
  logic [5:0] op [3];
  logic       zero [3];
  logic       memready [3];

  logic       memread [3], memwrite [3], alusrca [3], memtoreg [3], iord [3];
  logic       regwrite [3], regdst [3], pcen [3], illegal [3];
  logic [1:0] pcsource [3], alusrcb [3], aluop [3];
  logic [3:0] irw8;
  logic [1:0] irw16;
  logic [0:0] irw32;
  logic [18:0] got [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int steps_q [3][$];
  int rst_cnt [3];

  always #5 clk = ~clk;

  mips_mc_controller #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst[0]), .op(op[0]), .zero(zero[0]), .memready(memready[0]),
    .memread(memread[0]), .memwrite(memwrite[0]), .alusrca(alusrca[0]),
    .memtoreg(memtoreg[0]), .iord(iord[0]), .regwrite(regwrite[0]), .regdst(regdst[0]),
    .pcen(pcen[0]), .pcsource(pcsource[0]), .alusrcb(alusrcb[0]), .aluop(aluop[0]),
    .irwrite(irw8), .illegal(illegal[0])
  );

  mips_mc_controller #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst[1]), .op(op[1]), .zero(zero[1]), .memready(memready[1]),
    .memread(memread[1]), .memwrite(memwrite[1]), .alusrca(alusrca[1]),
    .memtoreg(memtoreg[1]), .iord(iord[1]), .regwrite(regwrite[1]), .regdst(regdst[1]),
    .pcen(pcen[1]), .pcsource(pcsource[1]), .alusrcb(alusrcb[1]), .aluop(aluop[1]),
    .irwrite(irw16), .illegal(illegal[1])
  );

  mips_mc_controller #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst[2]), .op(op[2]), .zero(zero[2]), .memready(memready[2]),
    .memread(memread[2]), .memwrite(memwrite[2]), .alusrca(alusrca[2]),
    .memtoreg(memtoreg[2]), .iord(iord[2]), .regwrite(regwrite[2]), .regdst(regdst[2]),
    .pcen(pcen[2]), .pcsource(pcsource[2]), .alusrcb(alusrcb[2]), .aluop(aluop[2]),
    .irwrite(irw32), .illegal(illegal[2])
  );

  // {irwrite[3:0], memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen,
  //  pcsource, alusrcb, aluop, illegal}
  assign got[0] = {irw8, memread[0], memwrite[0], alusrca[0], memtoreg[0], iord[0],
                   regwrite[0], regdst[0], pcen[0], pcsource[0], alusrcb[0], aluop[0],
                   illegal[0]};
  assign got[1] = {2'b00, irw16, memread[1], memwrite[1], alusrca[1], memtoreg[1], iord[1],
                   regwrite[1], regdst[1], pcen[1], pcsource[1], alusrcb[1], aluop[1],
                   illegal[1]};
  assign got[2] = {3'b000, irw32, memread[2], memwrite[2], alusrca[2], memtoreg[2], iord[2],
                   regwrite[2], regdst[2], pcen[2], pcsource[2], alusrcb[2], aluop[2],
                   illegal[2]};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, actual, expected);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] opc);
    return opc inside {6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000101,
                       6'b000010, 6'b001000};
  endfunction

  function automatic int beats_of(input int lane);
    return 32 / (8 << lane);
  endfunction

  // Expand one instruction into its step list; fetch steps carry the slot index.
  task automatic build_instr(input int lane, input logic [5:0] opc);
    for (int k = 0; k < beats_of(lane); k++) steps_q[lane].push_back(KFetch * 8 + k);
    steps_q[lane].push_back(KDecode * 8);
    case (opc)
      6'b100000: begin
        steps_q[lane].push_back(KMemAdr * 8);
        steps_q[lane].push_back(KLbRd * 8);
        steps_q[lane].push_back(KLbWr * 8);
      end
      6'b101000: begin
        steps_q[lane].push_back(KMemAdr * 8);
        steps_q[lane].push_back(KSbWr * 8);
      end
      6'b000000: begin
        steps_q[lane].push_back(KRtEx * 8);
        steps_q[lane].push_back(KRtWr * 8);
      end
      6'b000100: steps_q[lane].push_back(KBeqEx * 8);
      6'b000101: steps_q[lane].push_back(KBneEx * 8);
      6'b000010: steps_q[lane].push_back(KJEx * 8);
      6'b001000: begin
        steps_q[lane].push_back(KAddiEx * 8);
        steps_q[lane].push_back(KAddiWr * 8);
      end
      default: ;
    endcase
  endtask

  function automatic bit step_waits(input int step);
    int kind = step / 8;
    return (kind == KFetch) || (kind == KLbRd) || (kind == KSbWr);
  endfunction

  function automatic logic [18:0] exp_vec(input int step, input bit mr, input bit z,
                                          input logic [5:0] opc);
    int kind = step / 8;
    int idx = step % 8;
    logic [18:0] v = '0;
    case (kind)
      KFetch: begin
        v[14] = 1'b1; v[4:3] = 2'b01;
        if (mr) begin v[15 + idx] = 1'b1; v[7] = 1'b1; end
      end
      KDecode: begin
        v[4:3] = 2'b11;
        v[0] = !is_legal(opc);
      end
      KMemAdr: begin v[12] = 1'b1; v[4:3] = 2'b10; end
      KLbRd:   begin v[14] = 1'b1; v[10] = 1'b1; end
      KLbWr:   begin v[9] = 1'b1; v[11] = 1'b1; end
      KSbWr:   begin v[13] = 1'b1; v[10] = 1'b1; end
      KRtEx:   begin v[12] = 1'b1; v[2:1] = 2'b10; end
      KRtWr:   begin v[9] = 1'b1; v[8] = 1'b1; end
      KBeqEx:  begin v[12] = 1'b1; v[2:1] = 2'b01; v[6:5] = 2'b01; v[7] = z; end
      KBneEx:  begin v[12] = 1'b1; v[2:1] = 2'b01; v[6:5] = 2'b01; v[7] = !z; end
      KJEx:    begin v[6:5] = 2'b10; v[7] = 1'b1; end
      KAddiEx: begin v[12] = 1'b1; v[4:3] = 2'b10; end
      KAddiWr: v[9] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal_ops [7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
                                  6'b000101, 6'b000010, 6'b001000};
    logic [5:0] r;
    int sel = $urandom_range(0, 8);
    if (sel < 7) return legal_ops[sel];
    r = 6'($urandom);
    if (is_legal(r)) r = 6'b111111;
    return r;
  endfunction

  initial begin
    logic [18:0] exp;
    string tags [3] = '{"w8", "w16", "w32"};
    for (int l = 0; l < 3; l++) begin
      rst[l] = 1'b1; op[l] = '0; zero[l] = 1'b0; memready[l] = 1'b1; rst_cnt[l] = 2;
    end
    for (cyc = 0; cyc < NCycles; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if (rst_cnt[l] > 0) begin
          rst[l] = 1'b1;
          rst_cnt[l]--;
        end else if ($urandom_range(0, 149) == 0) begin
          rst[l] = 1'b1;
          rst_cnt[l] = $urandom_range(0, 2);
        end else begin
          rst[l] = 1'b0;
        end
        if (!rst[l] && steps_q[l].size() == 0) begin
          op[l] = pick_op();
          build_instr(l, op[l]);
        end
        memready[l] = ($urandom_range(0, 3) != 0);
        zero[l] = 1'($urandom);
      end
      #2;
      for (int l = 0; l < 3; l++) begin
        if (rst[l]) begin
          exp = '0;
          steps_q[l].delete();
        end else begin
          exp = exp_vec(steps_q[l][0], memready[l], zero[l], op[l]);
          if (!(step_waits(steps_q[l][0]) && !memready[l])) void'(steps_q[l].pop_front());
        end
        check(tags[l], 32'(got[l]), 32'(exp));
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Parametrised multicycle control unit for the TinyMIPS core. It replaces the fixed 8-bit, 4-byte-fetch controller and generalises the memory bus width, so that a 32-bit instruction is assembled in 32/WIDTH fetch beats. It adds a memory-ready handshake for wait states, the `bne` instruction and an illegal-opcode flag. It sits between the instruction register opcode field / ALU zero flag and the datapath control inputs; `alucontrol` is unchanged.

## Interface
- `WIDTH`, default 8: memory/datapath width; legal values 8, 16 and 32.
- `BEATS`, default 32/WIDTH (derived, do not override): fetch beats per instruction.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 6: `instr[31:26]`.
- `zero` input 1: ALU zero flag.
- `memready` input 1: memory access completes this cycle.
- `memread`, `memwrite` output 1 each: memory strobes.
- `alusrca`, `memtoreg`, `iord`, `regwrite`, `regdst` output 1 each: datapath selects and enables.
- `pcen` output 1: PC register enable.
- `pcsource`, `alusrcb`, `aluop` output 2 each: datapath mux and ALU selects.
- `irwrite` output BEATS: one-hot IR slot write enable; slot k holds instruction bits [WIDTH*(k+1)-1 : WIDTH*k].
- `illegal` output 1: unrecognised opcode pulse.

## Operation
- States:
  - FETCH0..FETCH(BEATS-1)
  - DECODE
  - MEMADR, LBRD, LBWR, SBWR
  - RTEX, RTWR
  - BEQEX, BNEEX, JEX
  - ADDIEX, ADDIWR
- FETCHk:
  - Drives memread=1, alusrca=0, alusrcb=01 (constant WIDTH/8), aluop=00, pcsource=00.
  - When memready=1: irwrite[k]=1, pcen=1, advance to FETCH(k+1) or DECODE.
  - When memready=0: irwrite=0, pcen=0, hold state.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precompute). Decode `op`:
  - 100000 lb and 101000 sb -> MEMADR
  - 000000 R-type -> RTEX
  - 000100 beq -> BEQEX
  - 000101 bne -> BNEEX
  - 000010 j -> JEX
  - 001000 addi -> ADDIEX
  - any other opcode -> illegal=1 for this cycle, next state FETCH0 (executed as NOP).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state LBRD if lb, SBWR if sb.
- LBRD: memread=1, iord=1; hold until memready=1, then LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0; then FETCH0.
- SBWR: memwrite=1, iord=1; hold until memready=1, then FETCH0.
- RTEX: alusrca=1, alusrcb=00, aluop=10; then RTWR.
- RTWR: regwrite=1, regdst=1, memtoreg=0; then FETCH0.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=zero; then FETCH0.
- BNEEX: same selects as BEQEX, pcen=~zero; then FETCH0.
- JEX: pcsource=10, pcen=1; then FETCH0.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; then ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0; then FETCH0.
- Any signal not listed for a state is 0.
- `memready` is ignored in every state that does not access memory.

## Timing
- Outputs are decoded combinationally from state. The only combinational input paths are: `pcen` from `zero` (branch states), `pcen`/`irwrite` from `memready` (FETCH), and `illegal` from `op` (DECODE).
- While rst=1, all outputs are 0. At the first edge with rst=1, state becomes FETCH0. Reset asserted mid-instruction aborts it with no further strobes.
- Cycles per instruction with memready held at 1:
  - R-type: BEATS+3
  - addi: BEATS+3
  - lb: BEATS+4
  - sb: BEATS+3
  - beq / bne / j: BEATS+2
  - illegal opcode: BEATS+1
- Each cycle of memready=0 in a memory state adds exactly one cycle. No strobe is dropped or duplicated while waiting.
- `op` is sampled only in DECODE and MEMADR. IR slots are stable after the last fetch beat.

## Test plan
- WIDTH=8, memready=1, R-type (op=000000): irwrite sequence 0001, 0010, 0100, 1000; then DECODE, RTEX (aluop=10); RTWR regwrite=1 regdst=1 at cycle 7; FETCH0 at cycle 8.
- WIDTH=32 (BEATS=1), lb with memready low for 2 cycles in LBRD: memread and iord stay 1 for 3 cycles; LBWR memtoreg=1 regwrite=1 follows; 7 cycles total.
- WIDTH=16, bne with zero=0 -> pcen=1 pcsource=01 in BNEEX. Repeat with zero=1 -> pcen=0. beq gives the inverse responses.
- Illegal op=111111: illegal=1 for exactly one cycle in DECODE; regwrite and memwrite never assert; next state FETCH0.
- rst asserted during FETCH2 (WIDTH=8): all outputs 0 while rst=1; after release, the first cycle is FETCH0 with memread=1 and irwrite=0001 when memready=1.
- Back-to-back sb, j, addi at WIDTH=8: memwrite exactly 1 cycle; JEX pcsource=10 pcen=1; ADDIWR regdst=0 regwrite=1; total 7+6+7 cycles.
